// File: rtl/coffee_order_scheduler.sv
// Round-robin scheduler sharing one coffee machine between N_REQ stations.
// Latches orders, grants one station, tracks machine status to completion.
module coffee_order_scheduler #(
  parameter int N_REQ           = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_milk,
  input  logic [2:0]       th_m,
  output logic             mach_start,
  output logic             mach_milk,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] served,
  output logic [N_REQ-1:0] pending,
  output logic             busy,
  output logic             need_milk,
  output logic             fault
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (COOLDOWN_CYCLES > 0) ?
                      $clog2(COOLDOWN_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    COOLDOWN
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] milk_q, milk_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] served_q, served_d;
  logic             mach_milk_q, mach_milk_d;
  logic             fault_q, fault_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CW-1:0]    ccnt_q, ccnt_d;

  logic             found;
  logic [PW-1:0]    win;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] clr;
  logic             done_code;
  logic             standby;
  logic             t_hit;
  logic             in_wait;

  // Scan upward from ptr+1 with wrap; ptr itself is checked last.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && pending_q[(int'(ptr_q) + k) % N_REQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign win_oh    = N_REQ'(1) << win;
  assign done_code = (th_m == 3'b101) || (th_m == 3'b110);
  assign standby   = (th_m == 3'b000) || (th_m == 3'b111);
  assign t_hit     = (tcnt_q >= TW'(TIMEOUT_CYCLES - 1));
  assign in_wait   = (state_q == WAIT_BUSY) ||
                     (state_q == WAIT_DONE);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    milk_d      = milk_q;
    grant_d     = grant_q;
    served_d    = '0;
    mach_milk_d = mach_milk_q;
    fault_d     = fault_q;
    ptr_d       = ptr_q;
    tcnt_d      = tcnt_q;
    ccnt_d      = ccnt_q;
    clr         = '0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          clr         = win_oh;
          grant_d     = win_oh;
          mach_milk_d = milk_q[win];
          ptr_d       = win;
          state_d     = START;
        end
      end
      START: begin
        tcnt_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        if (tcnt_q != TW'(TIMEOUT_CYCLES)) begin
          tcnt_d = tcnt_q + TW'(1);
        end
        // Completion wins over a timeout landing in the same cycle.
        if ((state_q == WAIT_DONE) && done_code) begin
          served_d    = grant_q;
          grant_d     = '0;
          mach_milk_d = 1'b0;
          ccnt_d      = '0;
          state_d     = COOLDOWN;
        end else if (t_hit) begin
          fault_d     = 1'b1;
          grant_d     = '0;
          mach_milk_d = 1'b0;
          ccnt_d      = '0;
          state_d     = COOLDOWN;
        end else if ((state_q == WAIT_BUSY) && !standby) begin
          state_d = WAIT_DONE;
        end
      end
      COOLDOWN: begin
        if (ccnt_q != CW'(COOLDOWN_CYCLES)) begin
          ccnt_d = ccnt_q + CW'(1);
        end else if (standby) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A slot freed by this cycle's grant may take a new order at once.
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (!pending_q[i] || clr[i])) begin
        pending_d[i] = 1'b1;
        milk_d[i]    = req_milk[i];
      end else if (clr[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      milk_q      <= '0;
      grant_q     <= '0;
      served_q    <= '0;
      mach_milk_q <= 1'b0;
      fault_q     <= 1'b0;
      ptr_q       <= PW'(N_REQ - 1);
      tcnt_q      <= '0;
      ccnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      milk_q      <= milk_d;
      grant_q     <= grant_d;
      served_q    <= served_d;
      mach_milk_q <= mach_milk_d;
      fault_q     <= fault_d;
      ptr_q       <= ptr_d;
      tcnt_q      <= tcnt_d;
      ccnt_q      <= ccnt_d;
    end
  end

  assign mach_start = (state_q == START);
  assign mach_milk  = mach_milk_q;
  assign grant      = grant_q;
  assign served     = served_q;
  assign pending    = pending_q;
  assign busy       = (state_q != IDLE);
  assign need_milk  = in_wait && (th_m == 3'b100);
  assign fault      = fault_q;

endmodule

// File: tb/tb_coffee_order_scheduler.sv
// Directed bench for coffee_order_scheduler.
// Small timeout so the fault path is reachable quickly.
module tb_coffee_order_scheduler;

  localparam int N = 4;
  localparam int T = 20;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_milk = '0;
  logic [2:0]   th_m = 3'b000;
  logic         mach_start;
  logic         mach_milk;
  logic [N-1:0] grant;
  logic [N-1:0] served;
  logic [N-1:0] pending;
  logic         busy;
  logic         need_milk;
  logic         fault;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_start = 0;
  int gap = 0;
  int served_cnt = 0;
  int served_base = 0;

  coffee_order_scheduler #(
    .N_REQ(N),
    .TIMEOUT_CYCLES(T),
    .COOLDOWN_CYCLES(C)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_milk(req_milk),
    .th_m(th_m),
    .mach_start(mach_start),
    .mach_milk(mach_milk),
    .grant(grant),
    .served(served),
    .pending(pending),
    .busy(busy),
    .need_milk(need_milk),
    .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (served != '0) served_cnt <= served_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    for (int n = 0; n < 60 && mach_start !== 1'b1; n++) tick();
    chk({tag, "_start"}, 32'(mach_start), 32'd1);
    gap = cyc - last_start;
    last_start = cyc;
  endtask

  // Machine model: 001 for two cycles, then DONE.
  task automatic run_service(input string tag,
                             input logic [N-1:0] g,
                             input logic m);
    wait_start(tag);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_milk"}, 32'(mach_milk), 32'(m));
    tick();
    th_m = 3'b001;
    tick();
    tick();
    th_m = 3'b101;
    tick();
    chk({tag, "_served"}, 32'(served), 32'(g));
    chk({tag, "_gclr"}, 32'(grant), 32'd0);
    th_m = 3'b000;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_start", 32'(mach_start), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_srv", 32'(served), 32'd0);
    reset = 1'b1;
    tick();

    // T1: single order with milk, full status sequence
    req = 4'b0001;
    req_milk = 4'b0001;
    tick();
    req = '0;
    req_milk = '0;
    chk("t1_pend", 32'(pending), 32'b0001);
    chk("t1_nostart", 32'(mach_start), 32'd0);
    tick();
    chk("t1_start", 32'(mach_start), 32'd1);
    chk("t1_grant", 32'(grant), 32'b0001);
    chk("t1_milk", 32'(mach_milk), 32'd1);
    chk("t1_pclr", 32'(pending), 32'd0);
    tick();
    chk("t1_pulse", 32'(mach_start), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    th_m = 3'b001;
    repeat (3) tick();
    th_m = 3'b010;
    tick();
    th_m = 3'b011;
    tick();
    chk("t1_milk_hold", 32'(mach_milk), 32'd1);
    chk("t1_nosrv", 32'(served), 32'd0);
    th_m = 3'b101;
    tick();
    chk("t1_served", 32'(served), 32'b0001);
    chk("t1_gclr", 32'(grant), 32'd0);
    chk("t1_mclr", 32'(mach_milk), 32'd0);
    th_m = 3'b110;
    tick();
    chk("t1_srv_1cyc", 32'(served), 32'd0);
    repeat (5) tick();
    chk("t1_cd_wait", 32'(busy), 32'd1);
    th_m = 3'b000;
    tick();
    chk("t1_idle", 32'(busy), 32'd0);

    // T2: all four at once after reset, round-robin order
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    req = 4'b1111;
    req_milk = 4'b1010;
    tick();
    req = '0;
    req_milk = '0;
    chk("t2_pend", 32'(pending), 32'b1111);
    run_service("t2a", 4'b0001, 1'b0);
    chk("t2_pend2", 32'(pending), 32'b1110);
    run_service("t2b", 4'b0010, 1'b1);
    chk("t2_gap_b", 32'(gap), 32'd10);
    run_service("t2c", 4'b0100, 1'b0);
    chk("t2_gap_c", 32'(gap), 32'd10);
    run_service("t2d", 4'b1000, 1'b1);
    chk("t2_gap_d", 32'(gap), 32'd10);

    // T3: station 2 last, then 1001 -> 1000 before 0001
    req = 4'b0100;
    tick();
    req = '0;
    run_service("t3a", 4'b0100, 1'b0);
    req = 4'b1001;
    req_milk = 4'b1000;
    tick();
    req = '0;
    req_milk = '0;
    run_service("t3b", 4'b1000, 1'b1);
    run_service("t3c", 4'b0001, 1'b0);

    // T4: timeout with stuck WORKING; repeat req keeps first milk
    req = 4'b0010;
    req_milk = 4'b0010;
    tick();
    req = '0;
    req_milk = '0;
    wait_start("t4");
    chk("t4_grant", 32'(grant), 32'b0010);
    served_base = served_cnt;
    th_m = 3'b001;
    req = 4'b0100;
    req_milk = 4'b0100;
    tick();
    req_milk = '0;
    tick();
    req = '0;
    chk("t4_pend", 32'(pending), 32'b0100);
    repeat (T - 2) tick();
    chk("t4_nofault", 32'(fault), 32'd0);
    tick();
    chk("t4_fault", 32'(fault), 32'd1);
    chk("t4_gclr", 32'(grant), 32'd0);
    chk("t4_mclr", 32'(mach_milk), 32'd0);
    chk("t4_nosrv", 32'(served_cnt - served_base), 32'd0);
    th_m = 3'b000;
    run_service("t4b", 4'b0100, 1'b1);
    chk("t4_sticky", 32'(fault), 32'd1);

    // T5: NEEDMILK for five cycles
    req = 4'b0001;
    req_milk = 4'b0001;
    tick();
    req = '0;
    req_milk = '0;
    wait_start("t5");
    tick();
    th_m = 3'b001;
    tick();
    chk("t5_nm0", 32'(need_milk), 32'd0);
    th_m = 3'b100;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_nm1", 32'(need_milk), 32'd1);
      chk("t5_grant", 32'(grant), 32'b0001);
      chk("t5_milk", 32'(mach_milk), 32'd1);
      tick();
    end
    th_m = 3'b010;
    #1;
    chk("t5_nm_off", 32'(need_milk), 32'd0);
    th_m = 3'b101;
    tick();
    chk("t5_served", 32'(served), 32'b0001);
    th_m = 3'b000;

    // T6: reset in WAIT_DONE with 0110 pending
    req = 4'b0001;
    tick();
    req = '0;
    wait_start("t6");
    chk("t6_grant", 32'(grant), 32'b0001);
    req = 4'b0110;
    tick();
    req = '0;
    th_m = 3'b001;
    tick();
    chk("t6_pend", 32'(pending), 32'b0110);
    chk("t6_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    chk("t6_r_grant", 32'(grant), 32'd0);
    chk("t6_r_pend", 32'(pending), 32'd0);
    chk("t6_r_busy", 32'(busy), 32'd0);
    chk("t6_r_srv", 32'(served), 32'd0);
    chk("t6_r_milk", 32'(mach_milk), 32'd0);
    chk("t6_r_nm", 32'(need_milk), 32'd0);
    chk("t6_r_fault", 32'(fault), 32'd0);
    chk("t6_r_start", 32'(mach_start), 32'd0);
    reset = 1'b1;
    th_m = 3'b000;
    req = 4'b0011;
    req_milk = 4'b0011;
    tick();
    req = '0;
    req_milk = '0;
    run_service("t6b", 4'b0001, 1'b1);

    for (int n = 0; n < 30 && busy !== 1'b0; n++) tick();
    chk("end_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
